decode_ctrl: RTL and testbench

- Decode-stage controller for the RV32I pipeline, sitting between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode into the 7-bit one-hot `types` vector.
- Drives the existing immediate generator and registers the decoded bundle into a skid-buffered pipeline stage with flush support.
- Provides full-throughput back-pressure without a combinational ready path from execute to fetch.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/decode_ctrl_immediate.sv | 51 +++++
 rtl/decode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_decode_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I decode definitions: base opcode constants, bit positions inside
// the one-hot instruction-type vector {R,I,L,S,J,B,U}, and the state encoding
// of the decode-stage skid controller.
// ----------------------------------------------------------------------------
package rv32_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // Bit positions in the types vector, MSB first: {R,I,L,S,J,B,U}
    localparam int NTYPES = 7;
    localparam int TYPE_R = 6;
    localparam int TYPE_I = 5;
    localparam int TYPE_L = 4;
    localparam int TYPE_S = 3;
    localparam int TYPE_J = 2;
    localparam int TYPE_B = 1;
    localparam int TYPE_U = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } dec_state_e;

endpackage

// File: rtl/decode_ctrl_immediate.sv
// ----------------------------------------------------------------------------
// immediate
// Immediate generator. Builds the XLEN-wide immediate of an RV32I instruction
// from the instruction word and its already-decoded one-hot type vector.
// Ports:
//   instr_i  - instruction word
//   opcode_i - opcode field (instr[6:0])
//   funct3_i - funct3 field (instr[14:12])
//   types_i  - one-hot {R,I,L,S,J,B,U}
//   imm_o    - immediate (zero when no type bit selects one)
// ----------------------------------------------------------------------------
module immediate
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   instr_i,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [NTYPES-1:0] types_i,
    output logic [XLEN-1:0]   imm_o
);

    // opcode bits come in separately and R-type carries no immediate
    logic unused_s;
    assign unused_s = ^{instr_i[6:0], types_i[TYPE_R]};

    // Immediate selection; I is tested before J so JALR (I|J) takes the I form
    always_comb begin
        imm_o = {XLEN{1'b0}};
        if (types_i[TYPE_I] && (opcode_i == OPC_OPIMM) && (funct3_i ==? 3'b?01)) begin
            // shift-immediate: only the shamt field, zero-extended
            imm_o = {{(XLEN-5){1'b0}}, instr_i[24:20]};
        end else if (types_i[TYPE_I] || types_i[TYPE_L]) begin
            imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end else if (types_i[TYPE_S]) begin
            imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end else if (types_i[TYPE_B]) begin
            imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
        end else if (types_i[TYPE_J]) begin
            imm_o = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
        end else if (types_i[TYPE_U]) begin
            imm_o = {instr_i[31:12], 12'b0};
        end else begin
            imm_o = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// ----------------------------------------------------------------------------
// decode_ctrl
// RV32I decode stage between fetch and execute. Classifies the incoming
// opcode, generates the immediate, and registers the bundle into a two-entry
// skid stage so that in_ready is a function of registered state only.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - fetch handshake; in_instr, in_pc payload
//   flush                 - drop everything held (branch redirect)
//   out_valid/out_ready   - execute handshake
//   out_pc, out_instr     - registered instruction and address
//   out_types, out_imm    - one-hot {R,I,L,S,J,B,U} and immediate
//   out_rd/rs1/rs2/funct3 - register indices and funct3
//   out_illegal           - unrecognised opcode (travels with the bundle)
// ----------------------------------------------------------------------------
module decode_ctrl
    import rv32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OP_LEN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    output logic [NTYPES-1:0] out_types,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic              out_illegal
);

    // bundle layout: {pc, instr, types, imm, illegal}
    localparam int BW = 3 * XLEN + NTYPES + 1;

    dec_state_e state_q, state_d;
    logic [BW-1:0] out_q, skid_q;
    logic [OP_LEN-1:0] opcode_s;
    logic [NTYPES-1:0] types_s;
    logic [XLEN-1:0] imm_s;
    logic illegal_s, accept_s, load_out_s, load_skid_s, move_skid_s;
    logic [BW-1:0] new_bundle_s;

    assign opcode_s = in_instr[OP_LEN-1:0];
    assign accept_s = in_valid & in_ready;

    // Opcode classification into the one-hot type vector
    always_comb begin
        types_s   = {NTYPES{1'b0}};
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP:                 types_s[TYPE_R] = 1'b1;
            OPC_OPIMM:              types_s[TYPE_I] = 1'b1;
            OPC_LOAD:               types_s[TYPE_L] = 1'b1;
            OPC_STORE:              types_s[TYPE_S] = 1'b1;
            OPC_JAL:                types_s[TYPE_J] = 1'b1;
            OPC_JALR: begin
                types_s[TYPE_I] = 1'b1;
                types_s[TYPE_J] = 1'b1;
            end
            OPC_BRANCH:             types_s[TYPE_B] = 1'b1;
            OPC_LUI, OPC_AUIPC:     types_s[TYPE_U] = 1'b1;
            // legal but carry no type and no immediate
            OPC_FENCE, OPC_SYSTEM:  types_s = {NTYPES{1'b0}};
            default:                illegal_s = 1'b1;
        endcase
    end

    immediate #(.XLEN(XLEN)) u_immediate (
        .instr_i  (in_instr),
        .opcode_i (opcode_s),
        .funct3_i (in_instr[14:12]),
        .types_i  (types_s),
        .imm_o    (imm_s)
    );

    assign new_bundle_s = {in_pc, in_instr, types_s, imm_s, illegal_s};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load control; flush overrides any accept
    always_comb begin
        state_d     = state_q;
        load_out_s  = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_FULL;
                        load_out_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && out_ready) begin
                        load_out_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = ST_SKID;
                        load_skid_s = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_d     = ST_FULL;
                        move_skid_s = 1'b1;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output and skid data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= {BW{1'b0}};
            skid_q <= {BW{1'b0}};
        end else begin
            if (load_out_s) begin
                out_q <= new_bundle_s;
            end else if (move_skid_s) begin
                out_q <= skid_q;
            end
            if (load_skid_s) begin
                skid_q <= new_bundle_s;
            end
        end
    end

    // Both handshake outputs decode only the state register
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);

    assign {out_pc, out_instr, out_types, out_imm, out_illegal} = out_q;
    assign out_rd     = out_instr[11:7];
    assign out_rs1    = out_instr[19:15];
    assign out_rs2    = out_instr[24:20];
    assign out_funct3 = out_instr[14:12];

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_instr, out_imm;
    logic [6:0]  out_types;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;

    always #5 clk = ~clk;

    decode_ctrl #(.XLEN(32), .OP_LEN(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_types(out_types), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] pc, instr, imm;
        logic [6:0]  types;
        logic        ill;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [6:0] types, input logic [31:0] imm,
                                input logic ill, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3);
        exp_t e;
        e.instr = instr; e.pc = pc; e.types = types; e.imm = imm; e.ill = ill;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks that a
    // stalled bundle does not change while it waits
    logic        hold_r = 1'b0;
    logic [31:0] hold_instr, hold_pc, hold_imm;
    always @(negedge clk) begin
        if (rst) begin
            hold_r = 1'b0;
        end else begin
            if (hold_r && out_valid) begin
                check("stable_instr", out_instr, hold_instr);
                check("stable_pc", out_pc, hold_pc);
                check("stable_imm", out_imm, hold_imm);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got instr 0x%08h expected no output", out_instr);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("instr", out_instr, e.instr);
                    check("pc", out_pc, e.pc);
                    check("types", {25'd0, out_types}, {25'd0, e.types});
                    check("imm", out_imm, e.imm);
                    check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    check("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    check("rs1", {27'd0, out_rs1}, {27'd0, e.rs1});
                    check("rs2", {27'd0, out_rs2}, {27'd0, e.rs2});
                    check("funct3", {29'd0, out_funct3}, {29'd0, e.f3});
                end
            end
            hold_r     = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_pc    = out_pc;
            hold_imm   = out_imm;
        end
    end

    // Drive one instruction until accepted; push its expectation if it must appear
    task automatic send(input exp_t e, input bit push);
        int  budget;
        logic rdy;
        budget   = 0;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc    = e.pc;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 50);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        end else if (push) begin
            sb_q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    exp_t e_addi, e_slli, e_lui, e_sw, e_beq, e_fence, e_jal, e_jalr, e_ill;

    initial begin
        e_addi  = mk(32'hFFF00093, 32'h100, 7'b0100000, 32'hFFFFFFFF, 1'b0, 5'd1,  5'd0, 5'd31, 3'd0);
        e_slli  = mk(32'h00309093, 32'h104, 7'b0100000, 32'h00000003, 1'b0, 5'd1,  5'd1, 5'd3,  3'd1);
        e_lui   = mk(32'h123452B7, 32'h108, 7'b0000001, 32'h12345000, 1'b0, 5'd5,  5'd8, 5'd3,  3'd5);
        e_sw    = mk(32'h0020A423, 32'h10C, 7'b0001000, 32'h00000008, 1'b0, 5'd8,  5'd1, 5'd2,  3'd2);
        e_beq   = mk(32'hFE000EE3, 32'h110, 7'b0000010, 32'hFFFFFFFC, 1'b0, 5'd29, 5'd0, 5'd0,  3'd0);
        e_fence = mk(32'h0000000F, 32'h114, 7'b0000000, 32'h00000000, 1'b0, 5'd0,  5'd0, 5'd0,  3'd0);
        e_jal   = mk(32'h008000EF, 32'h200, 7'b0000100, 32'h00000008, 1'b0, 5'd1,  5'd0, 5'd8,  3'd0);
        e_jalr  = mk(32'h00008067, 32'h204, 7'b0100100, 32'h00000000, 1'b0, 5'd0,  5'd1, 5'd0,  3'd0);
        e_ill   = mk(32'h0000007F, 32'h400, 7'b0000000, 32'h00000000, 1'b1, 5'd0,  5'd0, 5'd0,  3'd0);

        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // single addi with 1-cycle latency
        send(e_addi, 1'b1);
        @(negedge clk);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // slli then lui back to back: no bubble
        send(e_slli, 1'b1);
        send(e_lui, 1'b1);
        @(negedge clk);
        check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_out_instr", out_instr, 32'h123452B7);
        @(posedge clk); #1;

        send(e_sw, 1'b1);
        send(e_beq, 1'b1);
        send(e_fence, 1'b1);
        idle(3);

        // jal/jalr into the skid register while execute stalls
        out_ready = 1'b0;
        send(e_jal, 1'b1);
        send(e_jalr, 1'b1);
        @(negedge clk);
        check("skid_in_ready", {31'd0, in_ready}, 32'd0);
        check("skid_out_instr", out_instr, 32'h008000EF);
        idle(3);
        out_ready = 1'b1;
        idle(4);

        // flush from SKID with a simultaneous in_valid
        out_ready = 1'b0;
        send(e_addi, 1'b0);
        send(e_jal, 1'b0);
        in_valid = 1'b1; in_instr = 32'h00309093; in_pc = 32'h308; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_skid_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_skid_in_ready", {31'd0, in_ready}, 32'd1);

        // flush from FULL wins over an accept in the same cycle
        @(posedge clk); #1;
        send(e_lui, 1'b0);
        in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h30C; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        idle(4);

        // illegal opcode, then a normal instruction
        send(e_ill, 1'b1);
        send(e_addi, 1'b1);
        idle(3);

        // asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        send(e_sw, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_instr", out_instr, 32'd0);
        check("arst_out_imm", out_imm, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(e_beq, 1'b1);
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        idle(3);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
